wb_spi_slave: RTL and testbench

- SPI slave (responder) for an external SPI master, with a Wishbone slave register interface on the conbus, so an external host can exchange bytes with the LM32.
- Transfers are MSB-first with CPHA=0. CPOL is selectable.
- Single-byte RX holding register, single-byte TX holding register, and a level interrupt to intr_n.
- Pin inputs are oversampled in the clk domain through synchronizers. Requires clk ≥ 8× SCK.

---
 rtl/wb_spi_slave_pkg.sv | 39 +++
 rtl/wb_spi_slave_sync.sv | 54 +++++
 rtl/wb_spi_slave.sv | 182 ++++++++++++++++++
 tb/tb_wb_spi_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_slave_pkg.sv
// Shared constants and types for the Wishbone SPI slave.
package wb_spi_slave_pkg;

    localparam int unsigned WB_DW    = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BITCNT_W = 4;
    localparam int unsigned STATUS_W = 5;
    localparam int unsigned CTRL_W   = 3;

    localparam logic [BITCNT_W-1:0] BIT_LAST = 4'd8;
    localparam logic [BITCNT_W-1:0] BIT_PENULT = 4'd7;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned STAT_RX_FULL  = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_OVERRUN  = 2;
    localparam int unsigned STAT_UNDERRUN = 3;
    localparam int unsigned STAT_BUSY     = 4;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;
    localparam int unsigned CTRL_CPOL  = 2;

    typedef struct packed {
        logic cpol;
        logic tx_ie;
        logic rx_ie;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/wb_spi_slave_sync.sv
// Pin synchronizers for sck/cs_n/mosi with CPOL-adjusted SCK edge and CS edge pulses.
module spi_slave_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpol,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_lead_c,
    output logic sck_trail_c,
    output logic cs_fall_c,
    output logic cs_rise_c,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sck_h;
    logic                   cs_h;
    logic                   sck_now_c;
    logic                   sck_prev_c;

    // Idle levels: CS deasserted, SCK low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sck_h  <= 1'b0;
            cs_h   <= 1'b1;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sck_h  <= sck_q[SYNC_STAGES-1];
            cs_h   <= cs_q[SYNC_STAGES-1];
        end
    end

    // Both samples share cpol, so a CPOL change never fakes an edge.
    assign sck_now_c   = sck_q[SYNC_STAGES-1] ^ cpol;
    assign sck_prev_c  = sck_h ^ cpol;
    assign sck_lead_c  = sck_now_c & ~sck_prev_c;
    assign sck_trail_c = ~sck_now_c & sck_prev_c;
    assign cs_fall_c   = ~cs_q[SYNC_STAGES-1] & cs_h;
    assign cs_rise_c   = cs_q[SYNC_STAGES-1] & ~cs_h;
    assign cs_n_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/wb_spi_slave.sv
// SPI slave (CPHA=0, MSB first) with a Wishbone register interface and level interrupt.
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WB_DW-1:0]  wb_adr_i,
    input  logic [WB_DW-1:0]  wb_dat_i,
    output logic [WB_DW-1:0]  wb_dat_o,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    output logic              wb_ack_o,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              irq
);

    spi_state_e            state_q, state_d;
    ctrl_t                 ctrl_q;
    logic [BYTE_W-1:0]     rx_data_q, rx_shift_q, tx_hold_q, tx_shift_q;
    logic [BITCNT_W-1:0]   bitcnt_q;
    logic                  rx_full_q, tx_full_q, overrun_q, underrun_q;

    logic sck_lead_c, sck_trail_c, cs_fall_c, cs_rise_c, cs_n_s, mosi_s;
    logic wb_acc_c, rd_c, wr_c, rd_rx_c, wr_tx_c, wr_st_c, wr_ctrl_c;
    logic load_c, shift_tx_c, shift_rx_c, stop_c, byte_done_c;
    logic rx_take_c, ovr_set_c, unr_set_c;
    logic [BYTE_W-1:0]     tx_src_c, rx_byte_c;
    logic [STATUS_W-1:0]   status_c;
    logic                  unused_bits;

    assign unused_bits = ^{wb_adr_i[WB_DW-1:4], wb_adr_i[1:0], wb_dat_i[WB_DW-1:BYTE_W], wb_sel_i};

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst_n       (rst),
        .cpol        (ctrl_q.cpol),
        .sck         (spi_sck),
        .cs_n        (spi_cs_n),
        .mosi        (spi_mosi),
        .sck_lead_c  (sck_lead_c),
        .sck_trail_c (sck_trail_c),
        .cs_fall_c   (cs_fall_c),
        .cs_rise_c   (cs_rise_c),
        .cs_n_s      (cs_n_s),
        .mosi_s      (mosi_s)
    );

    // Bus access decode; effects land on the edge that raises ack.
    assign wb_acc_c  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_c      = wb_acc_c & ~wb_we_i;
    assign wr_c      = wb_acc_c & wb_we_i;
    assign rd_rx_c   = rd_c & (wb_adr_i[3:2] == REG_RXDATA);
    assign wr_tx_c   = wr_c & (wb_adr_i[3:2] == REG_TXDATA);
    assign wr_st_c   = wr_c & (wb_adr_i[3:2] == REG_STATUS);
    assign wr_ctrl_c = wr_c & (wb_adr_i[3:2] == REG_CTRL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall_c) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise_c) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Shifter control strobes; CS rise overrides any coincident SCK edge.
    always_comb begin
        load_c     = 1'b0;
        shift_tx_c = 1'b0;
        shift_rx_c = 1'b0;
        stop_c     = 1'b0;
        case (state_q)
            ST_IDLE: load_c = cs_fall_c;
            ST_ACTIVE: begin
                if (cs_rise_c) begin
                    stop_c = 1'b1;
                end else if (sck_lead_c) begin
                    shift_rx_c = 1'b1;
                end else if (sck_trail_c) begin
                    if (bitcnt_q == BIT_LAST) load_c = 1'b1;
                    else                      shift_tx_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign byte_done_c = shift_rx_c & (bitcnt_q == BIT_PENULT);
    assign rx_byte_c   = {rx_shift_q[BYTE_W-2:0], mosi_s};
    assign rx_take_c   = byte_done_c & (~rx_full_q | rd_rx_c);
    assign ovr_set_c   = byte_done_c & rx_full_q & ~rd_rx_c;
    assign unr_set_c   = load_c & ~tx_full_q;
    assign tx_src_c    = tx_full_q ? tx_hold_q : UNDERRUN_BYTE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bitcnt_q    <= '0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
        end else begin
            if (load_c) begin
                tx_shift_q  <= tx_src_c;
                bitcnt_q    <= '0;
                spi_miso    <= tx_src_c[BYTE_W-1];
                spi_miso_oe <= 1'b1;
            end else if (shift_tx_c) begin
                tx_shift_q <= {tx_shift_q[BYTE_W-2:0], 1'b0};
                spi_miso   <= tx_shift_q[BYTE_W-2];
            end else if (stop_c) begin
                bitcnt_q    <= '0;
                spi_miso    <= 1'b1;
                spi_miso_oe <= 1'b0;
            end
            if (shift_rx_c) begin
                rx_shift_q <= rx_byte_c;
                bitcnt_q   <= bitcnt_q + 4'd1;
            end
        end
    end

    // Holding registers and sticky flags; set wins over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q  <= '0;
            rx_full_q  <= 1'b0;
            tx_hold_q  <= '0;
            tx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            if (rx_take_c) rx_data_q <= rx_byte_c;
            if (rx_take_c)    rx_full_q <= 1'b1;
            else if (rd_rx_c) rx_full_q <= 1'b0;
            if (wr_tx_c) tx_hold_q <= wb_dat_i[BYTE_W-1:0];
            if (wr_tx_c)     tx_full_q <= 1'b1;
            else if (load_c) tx_full_q <= 1'b0;
            overrun_q  <= ovr_set_c | (overrun_q & ~(wr_st_c & wb_dat_i[STAT_OVERRUN]));
            underrun_q <= unr_set_c | (underrun_q & ~(wr_st_c & wb_dat_i[STAT_UNDERRUN]));
            if (wr_ctrl_c) ctrl_q <= ctrl_t'(wb_dat_i[CTRL_W-1:0]);
        end
    end

    assign status_c = {~cs_n_s, underrun_q, overrun_q, ~tx_full_q, rx_full_q};

    // Registered bus response and interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq      <= 1'b0;
        end else begin
            wb_ack_o <= wb_acc_c;
            if (rd_c) begin
                case (wb_adr_i[3:2])
                    REG_RXDATA: wb_dat_o <= WB_DW'(rx_data_q);
                    REG_STATUS: wb_dat_o <= WB_DW'(status_c);
                    REG_CTRL:   wb_dat_o <= WB_DW'(ctrl_q);
                    default:    wb_dat_o <= '0;
                endcase
            end
            irq <= (rx_full_q & ctrl_q.rx_ie) | (~tx_full_q & ctrl_q.tx_ie);
        end
    end

endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed self-checking bench for wb_spi_slave: vector table plus multi-cycle corner sequences.
module tb_wb_spi_slave;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, irq;
    logic        cpol_pin = 1'b0;

    int checks = 0;
    int failures = 0;

    wb_spi_slave #(.UNDERRUN_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_ack_o    (wb_ack_o),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] ra, input logic [31:0] wd,
                           output logic [31:0] rd);
        @(negedge clk);
        wb_adr_i = {28'd0, ra, 2'b00};
        wb_dat_i = wd;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge clk);
        check("wb_ack", 32'(wb_ack_o), 32'd1);
        rd = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] ra, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, ra, wd, dummy);
    endtask

    task automatic wb_rd_check(input string name, input logic [1:0] ra, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, ra, 32'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic cs_low();
        spi_sck  = cpol_pin;
        spi_cs_n = 1'b0;
    endtask

    task automatic cs_high();
        #(HALF);
        spi_cs_n = 1'b1;
        #(2*HALF);
    endtask

    // Master side, CPHA=0: data set up before the leading edge, MISO sampled at it.
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo[3'(7 - i)];
            #(HALF);
            mi = {mi[6:0], spi_miso};
            spi_sck = ~cpol_pin;
            #(HALF);
            spi_sck = cpol_pin;
        end
    endtask

    typedef struct {
        logic       cpol;
        logic [1:0] ie;
        logic       tx_valid;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        logic       exp_irq;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] mi, mi2;

        // A lone byte always ends with a reload at the final trailing edge, so underrun is set.
        vecs[0] = '{1'b0, 2'b01, 1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 1'b1, 8'h0B};
        vecs[1] = '{1'b0, 2'b00, 1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A, 1'b0, 8'h0B};
        vecs[2] = '{1'b1, 2'b01, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96, 1'b1, 8'h0B};
        vecs[3] = '{1'b1, 2'b10, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 8'h0B};
        vecs[4] = '{1'b0, 2'b00, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 1'b0, 8'h0B};

        #23;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd1);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        wb_rd_check("rst_status", 2'd2, 32'h02);
        wb_rd_check("rst_ctrl", 2'd3, 32'h00);

        for (int v = 0; v < 5; v++) begin
            wb_wr(2'd3, {29'd0, vecs[v].cpol, vecs[v].ie});
            cpol_pin = vecs[v].cpol;
            spi_sck  = cpol_pin;
            #(HALF);
            if (vecs[v].tx_valid) wb_wr(2'd1, {24'd0, vecs[v].tx});
            cs_low();
            spi_bits(vecs[v].mosi, 8, mi);
            cs_high();
            check($sformatf("v%0d_miso", v), 32'(mi), 32'(vecs[v].exp_miso));
            check($sformatf("v%0d_oe_off", v), 32'(spi_miso_oe), 32'd0);
            check($sformatf("v%0d_irq", v), 32'(irq), 32'(vecs[v].exp_irq));
            wb_rd_check($sformatf("v%0d_status", v), 2'd2, 32'(vecs[v].exp_status));
            wb_rd_check($sformatf("v%0d_rx", v), 2'd0, 32'(vecs[v].exp_rx));
            wb_wr(2'd2, 32'h0C);
            wb_rd_check($sformatf("v%0d_status_clr", v), 2'd2, 32'h02);
        end

        // Two bytes in one CS without reading: overrun and underrun on the second byte.
        wb_wr(2'd3, 32'h0);
        cpol_pin = 1'b0;
        spi_sck  = 1'b0;
        #(HALF);
        wb_wr(2'd1, 32'h11);
        cs_low();
        spi_bits(8'h01, 8, mi);
        spi_bits(8'h02, 8, mi2);
        cs_high();
        check("b2b_miso0", 32'(mi), 32'h11);
        check("b2b_miso1", 32'(mi2), 32'hFF);
        wb_rd_check("b2b_status", 2'd2, 32'h0F);
        wb_rd_check("b2b_rx", 2'd0, 32'h01);
        wb_wr(2'd2, 32'h04);
        wb_rd_check("b2b_w1c_ovr", 2'd2, 32'h0A);
        wb_wr(2'd2, 32'h08);
        wb_rd_check("b2b_w1c_unr", 2'd2, 32'h02);

        // Partial byte is dropped; the next full byte arrives intact.
        cs_low();
        spi_bits(8'hF0, 5, mi);
        cs_high();
        wb_rd_check("part_status", 2'd2, 32'h0A);
        wb_wr(2'd2, 32'h08);
        cs_low();
        spi_bits(8'h81, 8, mi);
        cs_high();
        check("part_next_miso", 32'(mi), 32'hFF);
        wb_rd_check("part_next_rx", 2'd0, 32'h81);
        wb_wr(2'd2, 32'h0C);

        // Reset in the middle of a byte, then a clean transfer.
        wb_wr(2'd3, 32'h02);
        wb_wr(2'd1, 32'h77);
        cs_low();
        spi_bits(8'hAA, 4, mi);
        check("mid_oe_on", 32'(spi_miso_oe), 32'd1);
        check("mid_irq_pre", 32'(irq), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_miso", 32'(spi_miso), 32'd1);
        check("mid_rst_oe", 32'(spi_miso_oe), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_ack", 32'(wb_ack_o), 32'd0);
        check("mid_rst_dat", wb_dat_o, 32'd0);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        wb_rd_check("mid_status", 2'd2, 32'h02);
        wb_wr(2'd1, 32'h5E);
        cs_low();
        spi_bits(8'h3C, 8, mi);
        cs_high();
        check("mid_next_miso", 32'(mi), 32'h5E);
        wb_rd_check("mid_next_rx", 2'd0, 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
